spi_slave_phy: RTL and testbench

// - SPI slave physical layer, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
// - Oversamples async sclk/cs_n/mosi in the clk domain. Deserialises MOSI into bytes for the

---
 rtl/spi_slave_phy.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_slave_phy.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_phy.sv
// ---------------------------------------------------------------------------
// spi_slave_phy
// SPI slave physical layer: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
// sclk, cs_n and mosi are oversampled in the clk domain through SYNC_STAGES
// flops each. Received bytes go to the command decoder on rx_data/rx_valid;
// response bytes come back on tx_data/tx_valid and are shifted out on MISO.
//
// Optional build macro: SPI_FRAME_ERR_EN
//   When defined, adds the frame_err output, which pulses for one clk when a
//   frame ends mid-byte or a sclk rise collides with the cs_n deassert.
//   When undefined, the port is absent and partial bytes are dropped silently.
// ---------------------------------------------------------------------------
module spi_slave_phy #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        cs_active
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic        frame_err
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchroniser chains; the last stage is the usable synchronised value.
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_n_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;
    logic                   cs_n_d_r;
    // Tracks which synchroniser stages (plus the cs_n delay flop) hold real
    // pin samples since reset. The chain reset value of cs_n is 1, so without
    // this a pin already low at reset release would look like a falling edge.
    logic [SYNC_STAGES:0]   primed_r;

    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   mosi_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   load_s;
    logic                   rx_edge_s;
    logic                   tx_edge_s;
    logic                   frame_end_s;

    logic [2:0]             bit_cnt_r;
    logic                   byte_done_r;
    logic [6:0]             rx_shift_r;
    logic [7:0]             rx_data_r;
    logic                   rx_valid_r;

    // tx_shift_r holds the bits still to be sent after the one on MISO.
    logic [6:0]             tx_shift_r;
    logic                   miso_r;
    logic [7:0]             hold_r;
    logic                   hold_full_r;
    logic [7:0]             load_byte_s;

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign cs_rise_s   = cs_n_s & ~cs_n_d_r;
    assign cs_fall_s   = primed_r[SYNC_STAGES] & ~cs_n_s & cs_n_d_r;

    assign miso      = miso_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign cs_active = (state_r == ST_ACTIVE);

    // Bring the asynchronous SPI pins into the clk domain and keep delayed copies for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_n_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
            cs_n_d_r    <= 1'b1;
            primed_r    <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            cs_n_sync_r <= {cs_n_sync_r[SYNC_STAGES-2:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sclk_d_r    <= sclk_s;
            cs_n_d_r    <= cs_n_s;
            primed_r    <= {primed_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle action decode; cs_n deassert takes priority over sclk edges.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        rx_edge_s    = 1'b0;
        tx_edge_s    = 1'b0;
        frame_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_next_s = ST_ACTIVE;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_s) begin
                    state_next_s = ST_IDLE;
                    frame_end_s  = 1'b1;
                end else begin
                    state_next_s = ST_ACTIVE;
                    rx_edge_s    = sclk_rise_s;
                    load_s       = sclk_fall_s & byte_done_r;
                    tx_edge_s    = sclk_fall_s & ~byte_done_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Select the next response byte: a coincident strobe bypasses, else the pending hold, else idle fill.
    always_comb begin
        load_byte_s = TX_IDLE;
        if (tx_valid) begin
            load_byte_s = tx_data;
        end else if (hold_full_r) begin
            load_byte_s = hold_r;
        end else begin
            load_byte_s = TX_IDLE;
        end
    end

    // Receive shifter, bit counter and byte-complete handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            rx_shift_r  <= 7'd0;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (frame_end_s) begin
                bit_cnt_r   <= 3'd0;
                byte_done_r <= 1'b0;
            end else if (rx_edge_s) begin
                rx_shift_r <= {rx_shift_r[5:0], mosi_s};
                if (bit_cnt_r == 3'd7) begin
                    rx_data_r   <= {rx_shift_r, mosi_s};
                    rx_valid_r  <= 1'b1;
                    bit_cnt_r   <= 3'd0;
                    byte_done_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end else if (load_s) begin
                byte_done_r <= 1'b0;
            end else begin
                byte_done_r <= byte_done_r;
            end
        end
    end

    // Transmit shifter and registered MISO pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= TX_IDLE[6:0];
            miso_r     <= TX_IDLE[7];
        end else begin
            if (frame_end_s) begin
                miso_r <= TX_IDLE[7];
            end else if (load_s) begin
                tx_shift_r <= load_byte_s[6:0];
                miso_r     <= load_byte_s[7];
            end else if (tx_edge_s) begin
                miso_r     <= tx_shift_r[6];
                tx_shift_r <= {tx_shift_r[5:0], 1'b0};
            end else begin
                miso_r <= miso_r;
            end
        end
    end

    // Response holding register; a load consumes it, the last strobe otherwise wins. Kept across frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r      <= TX_IDLE;
            hold_full_r <= 1'b0;
        end else begin
            if (load_s) begin
                hold_full_r <= 1'b0;
            end else if (tx_valid) begin
                hold_r      <= tx_data;
                hold_full_r <= 1'b1;
            end else begin
                hold_full_r <= hold_full_r;
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_r;

    assign frame_err = frame_err_r;

    // Flag frames that end mid-byte or whose final sclk rise is lost to the cs_n deassert.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= frame_end_s &
                           ((bit_cnt_r != 3'd0) | (sclk_rise_s & (bit_cnt_r != 3'd7)));
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_phy.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_phy
// Directed bench for spi_slave_phy. An SPI master model drives sclk/cs_n/mosi
// and samples MISO on each sclk rise. Expected received bytes are queued when
// a byte is driven; a monitor collects every rx_valid pulse and the two queues
// are compared at the end of each frame.
// ---------------------------------------------------------------------------
module tb_spi_slave_phy;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        cs_active;
`ifdef SPI_FRAME_ERR_EN
    logic        frame_err;
    int          fe_cnt = 0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  rx_exp[$];
    logic [7:0]  rx_got[$];
    logic [7:0]  mi;

    spi_slave_phy #(
        .SYNC_STAGES (2),
        .TX_IDLE     (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .cs_active (cs_active)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every received byte (one entry per clk that rx_valid is high).
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_got.push_back(rx_data);
    end

`ifdef SPI_FRAME_ERR_EN
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift the top nb bits of mo out on MOSI; half = clk cycles per sclk phase.
    task automatic spi_bits(input logic [7:0] mo, input int nb, input int half,
                            output logic [7:0] mo_mi);
        mo_mi = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            mosi = mo[i];
            repeat (half) @(negedge clk);
            mo_mi[i] = miso;
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi, input int half,
                        input string tag);
        logic [7:0] got_mi;
        rx_exp.push_back(mo);
        spi_bits(mo, 8, half, got_mi);
        chk(tag, got_mi, exp_mi);
    endtask

    // Wait (bounded) for rx_valid, then strobe one or two response bytes.
    task automatic strobe_after_rx(input logic [7:0] d0, input logic [7:0] d1, input bit two);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rx_wait_timeout", {7'd0, (n < 400)}, 8'h01);
        @(negedge clk);
        tx_data  = d0;
        tx_valid = 1'b1;
        @(negedge clk);
        if (two) begin
            tx_data = d1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 8'(rx_got.size()), 8'(rx_exp.size()));
        while (rx_got.size() > 0 && rx_exp.size() > 0) begin
            chk(tag, rx_got.pop_front(), rx_exp.pop_front());
        end
        rx_got.delete();
        rx_exp.delete();
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state, then sclk activity with cs_n high
        chk("reset_miso",      {7'd0, miso},      8'h01);
        chk("reset_rx_valid",  {7'd0, rx_valid},  8'h00);
        chk("reset_cs_active", {7'd0, cs_active}, 8'h00);
        chk("reset_rx_data",   rx_data,           8'h00);
        spi_bits(8'hA5, 8, 8, mi);
        chk("idle_miso", mi, 8'hFF);
        check_rx("idle_rx");

        // Two bytes, no response pending
        cs_low();
        chk("cs_active_on", {7'd0, cs_active}, 8'h01);
        xfer(8'h87, 8'hFF, 8, "f1_b0_miso");
        xfer(8'h5A, 8'hFF, 8, "f1_b1_miso");
        cs_high();
        chk("cs_active_off", {7'd0, cs_active}, 8'h00);
        check_rx("f1_rx");
`ifdef SPI_FRAME_ERR_EN
        chk("f1_frame_err", 8'(fe_cnt), 8'h00);
`endif

        // Response strobed just after the first byte goes out in the second
        cs_low();
        fork
            xfer(8'h89, 8'hFF, 8, "f2_b0_miso");
            strobe_after_rx(8'hC3, 8'h00, 1'b0);
        join
        xfer(8'h05, 8'hC3, 8, "f2_b1_miso");
        xfer(8'h00, 8'hFF, 8, "f2_b2_miso");
        cs_high();
        check_rx("f2_rx");

        // Two strobes before the load: the last one wins
        cs_low();
        fork
            xfer(8'h12, 8'hFF, 8, "f3_b0_miso");
            strobe_after_rx(8'h11, 8'h22, 1'b1);
        join
        xfer(8'h34, 8'h22, 8, "f3_b1_miso");
        cs_high();
        check_rx("f3_rx");

        // Strobe coincident with the frame-entry load bypasses the hold register
        cs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        xfer(8'h77, 8'h33, 8, "f4_b0_bypass");
        xfer(8'h78, 8'hFF, 8, "f4_b1_miso");
        cs_high();
        check_rx("f4_rx");

        // Frame ends after 5 bits: partial byte dropped, next frame clean
        cs_low();
        spi_bits(8'hF0, 5, 8, mi);
        chk("f5_partial_miso", mi, 8'hF8);
        cs_high();
        chk("f5_miso_idle", {7'd0, miso}, 8'h01);
        check_rx("f5_partial_rx");
`ifdef SPI_FRAME_ERR_EN
        chk("f5_frame_err", 8'(fe_cnt), 8'h01);
`endif
        cs_low();
        xfer(8'hA5, 8'hFF, 8, "f6_b0_miso");
        cs_high();
        check_rx("f6_rx");

        // Reset mid-byte with cs_n low: ignored until cs_n cycles high/low
        cs_low();
        spi_bits(8'hC3, 4, 8, mi);
        chk("f7_pre_rst_miso", mi, 8'hF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("f7_rst_miso",      {7'd0, miso},      8'h01);
        chk("f7_rst_cs_active", {7'd0, cs_active}, 8'h00);
        spi_bits(8'hFF, 8, 8, mi);
        chk("f7_ignored_miso", mi, 8'hFF);
        chk("f7_still_idle", {7'd0, cs_active}, 8'h00);
        check_rx("f7_ignored_rx");
        cs_high();
        cs_low();
        xfer(8'h3C, 8'hFF, 4, "f8_fast_miso");
        cs_high();
        check_rx("f8_fast_rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
